// File: rtl/delay_alloc_ctrl.sv
// Delay-line allocator for the shared delay RAM: bump-allocates per-pipeline regions,
// zero-fills each new line through the RAM write port and reports it to the owning pipeline.
module delay_alloc_ctrl #(
  parameter int data_width     = 16,
  parameter int mem_addr_width = 16,
  parameter int max_delays     = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [1:0]                      alloc_delay,
  input  logic [2*data_width-1:0]         delay_size_in,
  input  logic [2*data_width-1:0]         init_delay_in,
  input  logic [1:0]                      pipeline_full_reset,
  output logic                            busy,
  output logic                            mem_wr_en,
  output logic [mem_addr_width-1:0]       mem_wr_addr,
  output logic [data_width-1:0]           mem_wr_data,
  input  logic                            mem_wr_ready,
  output logic [1:0]                      alloc_done,
  output logic                            alloc_error,
  output logic [$clog2(max_delays)-1:0]   alloc_index,
  output logic [mem_addr_width-1:0]       alloc_base,
  output logic [mem_addr_width-1:0]       alloc_size,
  output logic [mem_addr_width-1:0]       alloc_read_offset,
  input  logic                            tbl_rd_pipeline,
  input  logic [$clog2(max_delays)-1:0]   tbl_rd_index,
  output logic [mem_addr_width-1:0]       tbl_rd_base,
  output logic [mem_addr_width-1:0]       tbl_rd_size,
  output logic                            tbl_rd_valid
);
  localparam int SW = 2 * data_width;
  localparam int AW = mem_addr_width;
  localparam int IW = $clog2(max_delays);
  localparam int CW = IW + 1;
  localparam logic [AW-1:0] HALF = {1'b1, {(AW-1){1'b0}}};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]                          state_q, state_d;
  logic                                pipe_q, pipe_d;
  logic [SW-1:0]                       size_q, size_d;
  logic [SW-1:0]                       init_q, init_d;
  logic [1:0][AW-1:0]                  ptr_q, ptr_d;
  logic [1:0][CW-1:0]                  cnt_q, cnt_d;
  logic [1:0][max_delays-1:0][AW-1:0]  tbl_base_q, tbl_base_d;
  logic [1:0][max_delays-1:0][AW-1:0]  tbl_size_q, tbl_size_d;
  logic [AW-1:0]                       line_base_q, line_base_d;
  logic [AW-1:0]                       line_size_q, line_size_d;
  logic [IW-1:0]                       line_idx_q, line_idx_d;
  logic [AW-1:0]                       clr_q, clr_d;
  logic                                err_q, err_d;
  logic [AW-1:0]                       rd_base_q, rd_base_d;
  logic [AW-1:0]                       rd_size_q, rd_size_d;
  logic                                rd_valid_q, rd_valid_d;

  logic          abort;
  logic          done_v;
  logic [1:0]    req;
  logic [AW-1:0] rem;
  logic [AW-1:0] new_base;
  logic [IW-1:0] widx;

  // A full reset of the owning pipeline kills the in-flight request silently.
  assign abort    = (state_q != IDLE) && pipeline_full_reset[pipe_q];
  assign req      = alloc_delay & ~pipeline_full_reset;
  assign rem      = HALF - ptr_q[pipe_q];
  assign new_base = (pipe_q ? HALF : '0) + ptr_q[pipe_q];
  assign widx     = cnt_q[pipe_q][IW-1:0];

  always_comb begin
    state_d     = state_q;
    pipe_d      = pipe_q;
    size_d      = size_q;
    init_d      = init_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    tbl_base_d  = tbl_base_q;
    tbl_size_d  = tbl_size_q;
    line_base_d = line_base_q;
    line_size_d = line_size_q;
    line_idx_d  = line_idx_q;
    clr_d       = clr_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req == 2'b11) begin
          err_d = 1'b1;
        end else if (req != 2'b00) begin
          pipe_d  = req[1];
          size_d  = delay_size_in;
          init_d  = init_delay_in;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (abort) begin
          state_d = IDLE;
        end else if (size_q == '0 || size_q > SW'(rem) || init_q > size_q ||
                     cnt_q[pipe_q] == CW'(max_delays)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tbl_base_d[pipe_q][widx] = new_base;
          tbl_size_d[pipe_q][widx] = size_q[AW-1:0];
          ptr_d[pipe_q]            = ptr_q[pipe_q] + size_q[AW-1:0];
          cnt_d[pipe_q]            = cnt_q[pipe_q] + CW'(1);
          line_base_d              = new_base;
          line_size_d              = size_q[AW-1:0];
          line_idx_d               = widx;
          clr_d                    = '0;
          state_d                  = CLEAR;
        end
      end
      CLEAR: begin
        if (abort) begin
          state_d = IDLE;
        end else if (mem_wr_ready) begin
          if (clr_q == line_size_q - AW'(1)) state_d = DONE;
          else                               clr_d   = clr_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Requests are never queued behind an allocation in progress.
    if (state_q != IDLE && alloc_delay != 2'b00) err_d = 1'b1;

    for (int p = 0; p < 2; p++) begin
      if (pipeline_full_reset[p]) begin
        ptr_d[p] = '0;
        cnt_d[p] = '0;
      end
    end

    rd_base_d  = tbl_base_q[tbl_rd_pipeline][tbl_rd_index];
    rd_size_d  = tbl_size_q[tbl_rd_pipeline][tbl_rd_index];
    rd_valid_d = {1'b0, tbl_rd_index} < cnt_q[tbl_rd_pipeline];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pipe_q      <= 1'b0;
      size_q      <= '0;
      init_q      <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      line_base_q <= '0;
      line_size_q <= '0;
      line_idx_q  <= '0;
      clr_q       <= '0;
      err_q       <= 1'b0;
      rd_base_q   <= '0;
      rd_size_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pipe_q      <= pipe_d;
      size_q      <= size_d;
      init_q      <= init_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      line_base_q <= line_base_d;
      line_size_q <= line_size_d;
      line_idx_q  <= line_idx_d;
      clr_q       <= clr_d;
      err_q       <= err_d;
      rd_base_q   <= rd_base_d;
      rd_size_q   <= rd_size_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // Table storage needs no reset: entries at or above cnt are never reported valid.
  always_ff @(posedge clk) begin
    tbl_base_q <= tbl_base_d;
    tbl_size_q <= tbl_size_d;
  end

  assign done_v            = (state_q == DONE) && !pipeline_full_reset[pipe_q];
  assign busy              = state_q != IDLE;
  assign mem_wr_en         = state_q == CLEAR;
  assign mem_wr_addr       = mem_wr_en ? line_base_q + clr_q : '0;
  assign mem_wr_data       = '0;
  assign alloc_done        = done_v ? (pipe_q ? 2'b10 : 2'b01) : 2'b00;
  assign alloc_error       = err_q;
  assign alloc_index       = done_v ? line_idx_q : '0;
  assign alloc_base        = done_v ? line_base_q : '0;
  assign alloc_size        = done_v ? line_size_q : '0;
  assign alloc_read_offset = done_v ? init_q[AW-1:0] : '0;
  assign tbl_rd_base       = rd_base_q;
  assign tbl_rd_size       = rd_size_q;
  assign tbl_rd_valid      = rd_valid_q;
endmodule

// File: tb/tb_delay_alloc_ctrl.sv
// Directed bench for delay_alloc_ctrl: a vector table of allocations plus
// hand sequences for stalls, aborts, capacity and busy rejection.
module tb_delay_alloc_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  alloc_delay = '0;
  logic [31:0] delay_size_in = '0;
  logic [31:0] init_delay_in = '0;
  logic [1:0]  pipeline_full_reset = '0;
  logic        busy, mem_wr_en;
  logic [15:0] mem_wr_addr;
  logic [15:0] mem_wr_data;
  logic        mem_wr_ready = 1'b1;
  logic [1:0]  alloc_done;
  logic        alloc_error;
  logic [2:0]  alloc_index;
  logic [15:0] alloc_base, alloc_size, alloc_read_offset;
  logic        tbl_rd_pipeline = 1'b0;
  logic [2:0]  tbl_rd_index = '0;
  logic [15:0] tbl_rd_base, tbl_rd_size;
  logic        tbl_rd_valid;

  delay_alloc_ctrl dut (
    .clk(clk), .reset(reset), .alloc_delay(alloc_delay),
    .delay_size_in(delay_size_in), .init_delay_in(init_delay_in),
    .pipeline_full_reset(pipeline_full_reset), .busy(busy),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ready(mem_wr_ready), .alloc_done(alloc_done), .alloc_error(alloc_error),
    .alloc_index(alloc_index), .alloc_base(alloc_base), .alloc_size(alloc_size),
    .alloc_read_offset(alloc_read_offset), .tbl_rd_pipeline(tbl_rd_pipeline),
    .tbl_rd_index(tbl_rd_index), .tbl_rd_base(tbl_rd_base), .tbl_rd_size(tbl_rd_size),
    .tbl_rd_valid(tbl_rd_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  frst;
    logic        pipe;
    logic [31:0] size;
    logic [31:0] init;
    logic        exp_err;
    logic [15:0] exp_base;
    logic [2:0]  exp_idx;
  } vec_t;

  logic        res_err, res_timeout, res_seq_ok;
  logic [1:0]  res_done;
  logic [15:0] res_base, res_size, res_off, res_first;
  logic [2:0]  res_idx;
  int          res_nwr;

  task automatic free_pipe(input logic [1:0] m);
    @(negedge clk); pipeline_full_reset = m;
    @(negedge clk); pipeline_full_reset = 2'b00;
  endtask

  task automatic run_alloc(input logic p, input logic [31:0] sz, input logic [31:0] in);
    res_done = '0; res_err = 0; res_timeout = 1; res_seq_ok = 1; res_nwr = 0;
    res_first = '0; res_base = '0; res_size = '0; res_off = '0; res_idx = '0;
    @(negedge clk);
    alloc_delay = p ? 2'b10 : 2'b01; delay_size_in = sz; init_delay_in = in;
    @(negedge clk);
    alloc_delay = 2'b00;
    for (int c = 0; c < 40000; c++) begin
      if (mem_wr_en && mem_wr_ready) begin
        if (res_nwr == 0) res_first = mem_wr_addr;
        else if (mem_wr_addr != res_first + 16'(res_nwr)) res_seq_ok = 0;
        res_nwr++;
      end
      if (alloc_done != 2'b00) begin
        res_done = alloc_done; res_base = alloc_base; res_size = alloc_size;
        res_off = alloc_read_offset; res_idx = alloc_index; res_timeout = 0;
        break;
      end
      if (alloc_error) begin
        res_err = 1; res_timeout = 0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic lookup(input string nm, input logic p, input logic [2:0] idx,
                        input logic exp_v, input logic [15:0] eb, input logic [15:0] es);
    @(negedge clk); tbl_rd_pipeline = p; tbl_rd_index = idx;
    @(negedge clk);
    chk({nm, "_valid"}, 64'(tbl_rd_valid), 64'(exp_v));
    if (exp_v) begin
      chk({nm, "_base"}, 64'(tbl_rd_base), 64'(eb));
      chk({nm, "_size"}, 64'(tbl_rd_size), 64'(es));
    end
  endtask

  vec_t vecs[10];

  initial begin
    logic pat[4];
    logic [15:0] addrs[8];
    int en_cnt, acc, acc_at_done, k, hits;
    logic done_seen;

    vecs[0] = '{2'b00, 1'b0, 32'd4,       32'd2,  1'b0, 16'h0000, 3'd0};
    vecs[1] = '{2'b00, 1'b1, 32'd100,     32'd0,  1'b0, 16'h8000, 3'd0};
    vecs[2] = '{2'b00, 1'b1, 32'd50,      32'd50, 1'b0, 16'h8064, 3'd1};
    vecs[3] = '{2'b00, 1'b0, 32'd0,       32'd0,  1'b1, 16'h0000, 3'd0};
    vecs[4] = '{2'b00, 1'b0, 32'd4,       32'd5,  1'b1, 16'h0000, 3'd0};
    vecs[5] = '{2'b01, 1'b0, 32'h8000,    32'd3,  1'b0, 16'h0000, 3'd0};
    vecs[6] = '{2'b00, 1'b0, 32'd1,       32'd0,  1'b1, 16'h0000, 3'd0};
    vecs[7] = '{2'b01, 1'b0, 32'h10000,   32'd0,  1'b1, 16'h0000, 3'd0};
    vecs[8] = '{2'b00, 1'b0, 32'h8001,    32'd0,  1'b1, 16'h0000, 3'd0};
    vecs[9] = '{2'b00, 1'b0, 32'd1,       32'd1,  1'b0, 16'h0000, 3'd0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_wr_en", 64'(mem_wr_en), 0);
    chk("rst_wr_addr", 64'(mem_wr_addr), 0);
    chk("rst_done", 64'(alloc_done), 0);
    chk("rst_error", 64'(alloc_error), 0);
    chk("rst_base", 64'(alloc_base), 0);
    chk("rst_rd_valid", 64'(tbl_rd_valid), 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].frst != 2'b00) free_pipe(vecs[i].frst);
      run_alloc(vecs[i].pipe, vecs[i].size, vecs[i].init);
      chk($sformatf("v%0d_timeout", i), 64'(res_timeout), 0);
      chk($sformatf("v%0d_err", i), 64'(res_err), 64'(vecs[i].exp_err));
      if (!vecs[i].exp_err) begin
        chk($sformatf("v%0d_done", i), 64'(res_done), vecs[i].pipe ? 64'd2 : 64'd1);
        chk($sformatf("v%0d_base", i), 64'(res_base), 64'(vecs[i].exp_base));
        chk($sformatf("v%0d_idx", i), 64'(res_idx), 64'(vecs[i].exp_idx));
        chk($sformatf("v%0d_size", i), 64'(res_size), 64'(vecs[i].size[15:0]));
        chk($sformatf("v%0d_off", i), 64'(res_off), 64'(vecs[i].init[15:0]));
        chk($sformatf("v%0d_nwr", i), 64'(res_nwr), 64'(vecs[i].size));
        chk($sformatf("v%0d_first", i), 64'(res_first), 64'(vecs[i].exp_base));
        chk($sformatf("v%0d_seq", i), 64'(res_seq_ok), 1);
      end
    end

    lookup("lk_p1_i1", 1'b1, 3'd1, 1'b1, 16'h8064, 16'd50);
    lookup("lk_p1_i2", 1'b1, 3'd2, 1'b0, 16'h0000, 16'd0);
    lookup("lk_p0_i0", 1'b0, 3'd0, 1'b1, 16'h0000, 16'd1);

    // Write-port stall: ready 1,0,1,0 on a size-2 line
    free_pipe(2'b01);
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0;
    en_cnt = 0; acc = 0; k = 0; done_seen = 0; acc_at_done = -1;
    @(negedge clk); alloc_delay = 2'b01; delay_size_in = 32'd2; init_delay_in = 32'd0;
    @(negedge clk); alloc_delay = 2'b00;
    for (int c = 0; c < 20; c++) begin
      if (alloc_done != 2'b00) begin done_seen = 1; acc_at_done = acc; break; end
      if (mem_wr_en) begin
        if (en_cnt < 8) addrs[en_cnt] = mem_wr_addr;
        en_cnt++;
        mem_wr_ready = (k < 4) ? pat[k] : 1'b1;
        k++;
        if (mem_wr_ready) acc++;
      end
      @(negedge clk);
    end
    mem_wr_ready = 1'b1;
    chk("stall_done_seen", 64'(done_seen), 1);
    chk("stall_en_cycles", 64'(en_cnt), 3);
    chk("stall_acc_at_done", 64'(acc_at_done), 2);
    chk("stall_addr0", 64'(addrs[0]), 0);
    chk("stall_addr1", 64'(addrs[1]), 1);
    chk("stall_addr2_hold", 64'(addrs[2]), 1);
    @(negedge clk);
    chk("stall_idle", 64'(busy), 0);

    // Abort mid-CLEAR
    @(negedge clk); alloc_delay = 2'b01; delay_size_in = 32'd10; init_delay_in = 32'd0;
    @(negedge clk); alloc_delay = 2'b00;
    acc = 0;
    for (int c = 0; c < 20 && acc < 3; c++) begin
      if (mem_wr_en) acc++;
      if (acc < 3) @(negedge clk);
    end
    chk("abort_in_clear", 64'(mem_wr_en), 1);
    pipeline_full_reset = 2'b01;
    @(negedge clk); pipeline_full_reset = 2'b00;
    chk("abort_wr_en", 64'(mem_wr_en), 0);
    chk("abort_busy", 64'(busy), 0);
    hits = 0;
    for (int c = 0; c < 5; c++) begin
      if (alloc_done != 2'b00 || alloc_error) hits++;
      @(negedge clk);
    end
    chk("abort_no_pulse", 64'(hits), 0);
    lookup("abort_lk_p0_i0", 1'b0, 3'd0, 1'b0, 16'h0000, 16'd0);
    run_alloc(1'b0, 32'd3, 32'd1);
    chk("post_abort_done", 64'(res_done), 1);
    chk("post_abort_base", 64'(res_base), 0);
    chk("post_abort_idx", 64'(res_idx), 0);

    // Capacity: 8 lines accepted, 9th rejected
    free_pipe(2'b01);
    for (int i = 0; i < 9; i++) begin
      run_alloc(1'b0, 32'd1, 32'd0);
      if (i < 8) begin
        chk($sformatf("cap%0d_done", i), 64'(res_done), 1);
        chk($sformatf("cap%0d_idx", i), 64'(res_idx), 64'(i));
        chk($sformatf("cap%0d_base", i), 64'(res_base), 64'(i));
      end else begin
        chk("cap8_err", 64'(res_err), 1);
      end
    end

    // Request while busy is rejected; running allocation completes
    free_pipe(2'b01);
    @(negedge clk); alloc_delay = 2'b01; delay_size_in = 32'd4; init_delay_in = 32'd0;
    @(negedge clk); alloc_delay = 2'b10;
    @(negedge clk); alloc_delay = 2'b00;
    chk("busy_err", 64'(alloc_error), 1);
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (alloc_done != 2'b00) begin
        done_seen = 1;
        chk("busy_done_bits", 64'(alloc_done), 1);
        chk("busy_done_size", 64'(alloc_size), 4);
        break;
      end
      @(negedge clk);
    end
    chk("busy_done_seen", 64'(done_seen), 1);

    // Simultaneous requests rejected in IDLE
    @(negedge clk); @(negedge clk); alloc_delay = 2'b11;
    @(negedge clk); alloc_delay = 2'b00;
    chk("both_err", 64'(alloc_error), 1);
    chk("both_busy", 64'(busy), 0);

    // Full reset in the same cycle as a request wins
    @(negedge clk); alloc_delay = 2'b01; pipeline_full_reset = 2'b01; delay_size_in = 32'd2;
    @(negedge clk); alloc_delay = 2'b00; pipeline_full_reset = 2'b00;
    chk("rstwin_busy", 64'(busy), 0);
    chk("rstwin_err", 64'(alloc_error), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
